// File: rtl/adc_sensor_conditioner_if.sv
// Signal bundle between the ADC front end and the sensor conditioner.
// The master side supplies the raw ADC codes; the slave side returns the conditioned results.
interface adc_sensor_conditioner_if;
    logic [7:0] adc_accel;
    logic [7:0] adc_cds;
    logic [7:0] avg_accel;
    logic [7:0] avg_cds;
    logic [6:0] throttle_pct;
    logic       night_mode;
    logic       sample_valid;
    logic       overrun;

    modport master (
        output adc_accel, adc_cds,
        input  avg_accel, avg_cds, throttle_pct, night_mode, sample_valid, overrun
    );

    modport slave (
        input  adc_accel, adc_cds,
        output avg_accel, avg_cds, throttle_pct, night_mode, sample_valid, overrun
    );
endinterface

// File: rtl/adc_sensor_conditioner.sv
// Periodic sampling, boxcar averaging, dead-zoned throttle mapping via a serial divider,
// and a debounced, hysteretic night flag derived from the light sensor.
module adc_sensor_conditioner #(
    parameter int CLK_HZ     = 50000000,
    parameter int SAMPLE_HZ  = 1000,
    parameter int AVG_LOG2   = 3,
    parameter int DEAD_LO    = 16,
    parameter int DEAD_HI    = 240,
    parameter int DARK_ON    = 60,
    parameter int DARK_OFF   = 90,
    parameter int NIGHT_HOLD = 250
) (
    input logic                      clk,
    input logic                      rst,
    adc_sensor_conditioner_if.slave  bus
);
    localparam int PERIOD = CLK_HZ / SAMPLE_HZ;
    localparam int CNT_W  = $clog2(PERIOD);
    localparam int DEPTH  = 1 << AVG_LOG2;
    localparam int SUM_W  = 8 + AVG_LOG2;
    localparam int HOLD_W = $clog2(NIGHT_HOLD + 1);
    localparam logic [CNT_W-1:0] TICK_TERM = CNT_W'(PERIOD - 1);
    localparam logic [7:0]       DIVISOR   = 8'(DEAD_HI - DEAD_LO);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DIV   = 2'd2;
    localparam logic [1:0] OUT   = 2'd3;

    // channel 0 = accelerator, channel 1 = light sensor
    logic [CNT_W-1:0]                tick_cnt_q;
    logic [1:0]                      state_q, state_d;
    logic [1:0][7:0]                 cap_q;
    logic [1:0][DEPTH-1:0][7:0]      buf_q;
    logic [1:0][SUM_W-1:0]           sum_q;
    logic [AVG_LOG2-1:0]             wr_ptr_q;
    logic [3:0]                      div_cnt_q;
    logic [7:0]                      rem_q;
    logic [14:0]                     quo_q;
    logic                            force_full_q;
    logic [HOLD_W-1:0]               hold_q;
    logic [7:0]                      avg_accel_q, avg_cds_q;
    logic [6:0]                      throttle_q;
    logic                            night_q, valid_q;

    logic       tick;
    logic [7:0] avg_a_new, avg_c_new, diff;
    logic [14:0] num;
    logic [8:0] trial;
    logic       trial_ge, dark_qual;

    assign tick      = (tick_cnt_q == TICK_TERM);
    assign avg_a_new = sum_q[0][SUM_W-1:AVG_LOG2];
    assign avg_c_new = sum_q[1][SUM_W-1:AVG_LOG2];
    assign diff      = avg_a_new - 8'(DEAD_LO);
    assign num       = (avg_a_new <= 8'(DEAD_LO)) ? 15'd0 : 15'(diff) * 15'd100;
    assign trial     = {rem_q, quo_q[14]};
    assign trial_ge  = (trial >= {1'b0, DIVISOR});
    assign dark_qual = night_q ? (avg_c_new > 8'(DARK_OFF)) : (avg_c_new < 8'(DARK_ON));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tick) state_d = ACCUM;
            ACCUM:   state_d = DIV;
            DIV:     if (div_cnt_q == 4'd15) state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q   <= '0;
            state_q      <= IDLE;
            cap_q        <= '0;
            buf_q        <= '0;
            sum_q        <= '0;
            wr_ptr_q     <= '0;
            div_cnt_q    <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            force_full_q <= 1'b0;
            hold_q       <= '0;
            avg_accel_q  <= '0;
            avg_cds_q    <= '0;
            throttle_q   <= '0;
            night_q      <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + CNT_W'(1);
            state_q    <= state_d;
            valid_q    <= 1'b0;
            case (state_q)
                IDLE: if (tick) begin
                    cap_q[0] <= bus.adc_accel;
                    cap_q[1] <= bus.adc_cds;
                end
                ACCUM: begin
                    for (int c = 0; c < 2; c++) begin
                        sum_q[c] <= sum_q[c] - SUM_W'(buf_q[c][wr_ptr_q]) + SUM_W'(cap_q[c]);
                        buf_q[c][wr_ptr_q] <= cap_q[c];
                    end
                    wr_ptr_q  <= wr_ptr_q + AVG_LOG2'(1);
                    div_cnt_q <= '0;
                end
                DIV: begin
                    div_cnt_q <= div_cnt_q + 4'd1;
                    // first DIV cycle loads the numerator, the remaining 15 retire one quotient bit each
                    if (div_cnt_q == 4'd0) begin
                        rem_q        <= '0;
                        quo_q        <= num;
                        force_full_q <= (avg_a_new >= 8'(DEAD_HI));
                    end else begin
                        rem_q <= trial_ge ? 8'(trial - {1'b0, DIVISOR}) : trial[7:0];
                        quo_q <= {quo_q[13:0], trial_ge};
                    end
                end
                OUT: begin
                    avg_accel_q <= avg_a_new;
                    avg_cds_q   <= avg_c_new;
                    throttle_q  <= force_full_q ? 7'd100 : quo_q[6:0];
                    valid_q     <= 1'b1;
                    if (dark_qual) begin
                        if (hold_q == HOLD_W'(NIGHT_HOLD - 1)) begin
                            night_q <= ~night_q;
                            hold_q  <= '0;
                        end else begin
                            hold_q <= hold_q + HOLD_W'(1);
                        end
                    end else begin
                        hold_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.avg_accel    = avg_accel_q;
    assign bus.avg_cds      = avg_cds_q;
    assign bus.throttle_pct = throttle_q;
    assign bus.night_mode   = night_q;
    assign bus.sample_valid = valid_q;
    // a tick seen outside IDLE is simply dropped
    assign bus.overrun      = tick && (state_q != IDLE);
endmodule

// File: tb/tb_adc_sensor_conditioner.sv
// Directed bench: main instance at a 32-cycle sample period, second instance at a
// 10-cycle period so that ticks land while the FSM is busy.
module tb_adc_sensor_conditioner;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_o = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    adc_sensor_conditioner_if bus();
    adc_sensor_conditioner_if bus_o();

    adc_sensor_conditioner #(.CLK_HZ(32), .SAMPLE_HZ(1), .NIGHT_HOLD(4)) u_dut (
        .clk(clk), .rst(rst), .bus(bus));
    adc_sensor_conditioner #(.CLK_HZ(10), .SAMPLE_HZ(1), .NIGHT_HOLD(4)) u_ovr (
        .clk(clk), .rst(rst_o), .bus(bus_o));

    task automatic sample(input logic [7:0] a, input logic [7:0] c);
        bus.adc_accel = a;
        bus.adc_cds   = c;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.sample_valid) return;
        end
        n_cmp++; n_bad++;
        $display("FAIL valid_timeout: got no sample_valid within 100 cycles, required one");
    endtask

    // releases reset and checks the first valid lands 50 cycles later with zero outputs before it
    task automatic release_and_first_valid(input string tag);
        int  cyc = -1;
        bit  nz  = 1'b0;
        rst = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (bus.sample_valid) begin cyc = i; break; end
            if ({bus.avg_accel, bus.avg_cds, bus.throttle_pct, bus.night_mode} !== 24'd0) nz = 1'b1;
        end
        n_cmp++;
        if (nz) begin n_bad++; $display("FAIL %s_hold_zero: got nonzero output before first valid, required 0", tag); end
        n_cmp++;
        if (cyc != 50) begin n_bad++; $display("FAIL %s_first_valid: got cycle %0d required 50", tag, cyc); end
    endtask

    task automatic test_reset;
        bus.adc_accel = 8'd200; bus.adc_cds = 8'd255;
        bus_o.adc_accel = 8'd0; bus_o.adc_cds = 8'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.avg_accel, bus.avg_cds, bus.throttle_pct, bus.night_mode, bus.sample_valid, bus.overrun} !== 26'd0) begin
            n_bad++; $display("FAIL reset_outputs: got nonzero outputs in reset, required all 0");
        end
        release_and_first_valid("reset");
        n_cmp++;
        if (bus.avg_accel !== 8'd25) begin n_bad++; $display("FAIL reset_avg_accel: got %0d required 25", bus.avg_accel); end
        n_cmp++;
        if (bus.avg_cds !== 8'd31) begin n_bad++; $display("FAIL reset_avg_cds: got %0d required 31", bus.avg_cds); end
        n_cmp++;
        if (bus.throttle_pct !== 7'd4) begin n_bad++; $display("FAIL reset_throttle: got %0d required 4", bus.throttle_pct); end
        @(negedge clk);
        n_cmp++;
        if (bus.sample_valid !== 1'b0) begin n_bad++; $display("FAIL valid_pulse_width: got %0b required 0", bus.sample_valid); end
    endtask

    task automatic test_throttle;
        sample(8'd128, 8'd255);
        n_cmp++;
        if ({bus.avg_accel, 1'b0, bus.throttle_pct} !== {8'd41, 1'b0, 7'd11}) begin
            n_bad++; $display("FAIL ramp_128: got avg %0d thr %0d required avg 41 thr 11", bus.avg_accel, bus.throttle_pct);
        end
        repeat (7) sample(8'd128, 8'd255);
        n_cmp++;
        if ({bus.avg_accel, 1'b0, bus.throttle_pct} !== {8'd128, 1'b0, 7'd50}) begin
            n_bad++; $display("FAIL hold_128: got avg %0d thr %0d required avg 128 thr 50", bus.avg_accel, bus.throttle_pct);
        end
        n_cmp++;
        if (bus.avg_cds !== 8'd255) begin n_bad++; $display("FAIL cds_full: got %0d required 255", bus.avg_cds); end
        repeat (8) sample(8'd200, 8'd255);
        n_cmp++;
        if ({bus.avg_accel, 1'b0, bus.throttle_pct} !== {8'd200, 1'b0, 7'd82}) begin
            n_bad++; $display("FAIL hold_200: got avg %0d thr %0d required avg 200 thr 82", bus.avg_accel, bus.throttle_pct);
        end
    endtask

    task automatic test_deadzone;
        logic [7:0] v[5];
        logic [6:0] e[5];
        v = '{8'd16, 8'd17, 8'd239, 8'd240, 8'd255};
        e = '{7'd0, 7'd0, 7'd99, 7'd100, 7'd100};
        for (int k = 0; k < 5; k++) begin
            repeat (8) sample(v[k], 8'd255);
            n_cmp++;
            if ({bus.avg_accel, 1'b0, bus.throttle_pct} !== {v[k], 1'b0, e[k]}) begin
                n_bad++;
                $display("FAIL deadzone_%0d: got avg %0d thr %0d required avg %0d thr %0d",
                         v[k], bus.avg_accel, bus.throttle_pct, v[k], e[k]);
            end
        end
    endtask

    task automatic test_night;
        for (int k = 1; k <= 11; k++) begin
            sample(8'd255, 8'd40);
            n_cmp++;
            if (bus.night_mode !== (k == 11)) begin n_bad++; $display("FAIL night_enter_%0d: got %0b required %0b", k, bus.night_mode, k == 11); end
            if (k == 8) begin
                n_cmp++;
                if (bus.avg_cds !== 8'd40) begin n_bad++; $display("FAIL night_avg40: got %0d required 40", bus.avg_cds); end
            end
        end
        for (int k = 1; k <= 20; k++) begin
            sample(8'd255, 8'd75);
            n_cmp++;
            if (bus.night_mode !== 1'b1) begin n_bad++; $display("FAIL night_hyst_%0d: got %0b required 1", k, bus.night_mode); end
        end
        n_cmp++;
        if (bus.avg_cds !== 8'd75) begin n_bad++; $display("FAIL night_avg75: got %0d required 75", bus.avg_cds); end
        for (int k = 1; k <= 8; k++) begin
            sample(8'd255, 8'd120);
            n_cmp++;
            if (bus.night_mode !== (k < 6)) begin n_bad++; $display("FAIL night_exit_%0d: got %0b required %0b", k, bus.night_mode, k < 6); end
            if (k == 3) begin
                n_cmp++;
                if (bus.avg_cds !== 8'd91) begin n_bad++; $display("FAIL night_avg91: got %0d required 91", bus.avg_cds); end
            end
        end
        for (int k = 1; k <= 10; k++) begin
            sample(8'd255, 8'd55);
            n_cmp++;
            if (bus.night_mode !== 1'b0) begin n_bad++; $display("FAIL night_pre_%0d: got %0b required 0", k, bus.night_mode); end
        end
        sample(8'd255, 8'd255);
        n_cmp++;
        if ({bus.avg_cds, bus.night_mode} !== {8'd80, 1'b0}) begin
            n_bad++; $display("FAIL night_spike: got avg %0d night %0b required avg 80 night 0", bus.avg_cds, bus.night_mode);
        end
        for (int j = 1; j <= 11; j++) begin
            sample(8'd255, 8'd55);
            n_cmp++;
            if (bus.night_mode !== (j == 11)) begin n_bad++; $display("FAIL night_recount_%0d: got %0b required %0b", j, bus.night_mode, j == 11); end
            if (j == 8) begin
                n_cmp++;
                if (bus.avg_cds !== 8'd55) begin n_bad++; $display("FAIL night_avg55: got %0d required 55", bus.avg_cds); end
            end
        end
    endtask

    task automatic test_reset_mid_div;
        sample(8'd128, 8'd255);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.avg_accel, bus.avg_cds, bus.throttle_pct, bus.night_mode, bus.sample_valid, bus.overrun} !== 26'd0) begin
            n_bad++; $display("FAIL middiv_reset_outputs: got nonzero outputs during reset, required all 0");
        end
        repeat (2) @(negedge clk);
        release_and_first_valid("middiv");
        n_cmp++;
        if ({bus.avg_accel, bus.avg_cds, 1'b0, bus.throttle_pct} !== {8'd16, 8'd31, 1'b0, 7'd0}) begin
            n_bad++; $display("FAIL middiv_resume: got avg %0d cds %0d thr %0d required 16 31 0",
                              bus.avg_accel, bus.avg_cds, bus.throttle_pct);
        end
    endtask

    task automatic test_overrun;
        int nv = 0;
        int no = 0;
        bus_o.adc_accel = 8'd100; bus_o.adc_cds = 8'd100;
        @(negedge clk);
        rst_o = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            logic ev, eo;
            @(negedge clk);
            ev = (k >= 28) && ((k - 28) % 20 == 0);
            eo = (k >= 19) && ((k - 19) % 20 == 0);
            nv += int'(bus_o.sample_valid);
            no += int'(bus_o.overrun);
            n_cmp++;
            if ({bus_o.sample_valid, bus_o.overrun} !== {ev, eo}) begin
                n_bad++; $display("FAIL overrun_cycle_%0d: got valid %0b ovr %0b required valid %0b ovr %0b",
                                  k, bus_o.sample_valid, bus_o.overrun, ev, eo);
            end
        end
        n_cmp++;
        if (nv != 4 || no != 5) begin
            n_bad++; $display("FAIL overrun_counts: got valids %0d overruns %0d required 4 and 5", nv, no);
        end
    endtask

    initial begin
        test_reset();
        test_throttle();
        test_deadzone();
        test_night();
        test_reset_mid_div();
        test_overrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
